uart_tx_arbiter: RTL and testbench



---
 rtl/uart_arb_pkg.sv | 18 +
 rtl/uart_tx_arbiter_rr_pick.sv | 30 +++
 rtl/uart_tx_arbiter.sv | 187 ++++++++++++++++++
 tb/tb_uart_tx_arbiter.sv | 327 ++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/uart_arb_pkg.sv
// Shared types and constants for the UART TX arbiter and related shared-resource arbiters.
// Pure declarations; no logic, no latency, no flow control.
package uart_arb_pkg;

   typedef enum logic [1:0] {
      S_ARB       = 2'd0,
      S_SEND      = 2'd1,
      S_WAIT_BUSY = 2'd2,
      S_WAIT_DONE = 2'd3
   } arb_state_t;

   localparam logic [7:0] HDR_BASE = 8'hA0;

   function automatic int burst_cnt_w(input int max_burst);
      return $clog2(max_burst + 1);
   endfunction

endpackage

// File: rtl/uart_tx_arbiter_rr_pick.sv
// Combinational round-robin pick: first set request at or after ptr_i, wrapping.
// Zero latency; no flow control, the caller decides when to register the result.
module rr_pick #(
   parameter int N  = 4,
   parameter int IW = (N > 1) ? $clog2(N) : 1
) (
   input  logic [N-1:0]  req_i,
   input  logic [IW-1:0] ptr_i,
   output logic [N-1:0]  gnt_o,
   output logic [IW-1:0] idx_o,
   output logic          any_o
);

   always_comb begin
      int c;
      c     = 0;
      gnt_o = '0;
      idx_o = '0;
      any_o = 1'b0;
      for (int i = 0; i < N; i++) begin
         c = (int'(ptr_i) + i) % N;
         if (!any_o && req_i[c]) begin
            any_o    = 1'b1;
            gnt_o[c] = 1'b1;
            idx_o    = IW'(c);
         end
      end
   end

endmodule

// File: rtl/uart_tx_arbiter.sv
// Round-robin share of one UART TX among NUM_REQ byte streams; UART_ARB_HEADER_EN prefixes each grant with 8'hA0|index.
// Latency: grant registered one cycle after a valid is seen idle; byte strobes are combinational in S_SEND.
// Backpressure: one byte in flight; o_req_ready stays low until the TX busy pulse has risen and fallen.
module uart_tx_arbiter
   import uart_arb_pkg::*;
#(
   parameter int NUM_REQ   = 4,
   parameter int MAX_BURST = 16
) (
   input  logic                 i_clk,
   input  logic                 i_reset,
   input  logic [NUM_REQ-1:0]   i_req_valid,
   input  logic [NUM_REQ*8-1:0] i_req_data,
   input  logic [NUM_REQ-1:0]   i_req_last,
   output logic [NUM_REQ-1:0]   o_req_ready,
   output logic                 o_tx_valid,
   output logic [7:0]           o_tx_data,
   input  logic                 i_tx_busy,
   output logic [NUM_REQ-1:0]   o_grant,
   output logic                 o_active
);

   localparam int IW = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;
   localparam int BW = burst_cnt_w(MAX_BURST);

   arb_state_t         state_q;
   logic [IW-1:0]      ptr_q;
   logic [IW-1:0]      idx_q;
   logic [BW-1:0]      burst_q;
   logic [NUM_REQ-1:0] grant_q;
   logic               last_q;
   logic               active_q;
`ifdef UART_ARB_HEADER_EN
   logic               hdr_q;
`endif

   logic [NUM_REQ-1:0] pick_gnt;
   logic [IW-1:0]      pick_idx;
   logic               pick_any;

   logic [7:0]         own_data;
   logic               own_valid;
   logic               own_last;
   logic               tx_fire;
   logic [IW-1:0]      next_ptr;

   rr_pick #(
      .N  (NUM_REQ),
      .IW (IW)
   ) u_pick (
      .req_i (i_req_valid),
      .ptr_i (ptr_q),
      .gnt_o (pick_gnt),
      .idx_o (pick_idx),
      .any_o (pick_any)
   );

   // Owner's lane selected through the one-hot grant rather than by index arithmetic.
   always_comb begin
      own_data  = 8'h00;
      own_valid = 1'b0;
      own_last  = 1'b0;
      for (int k = 0; k < NUM_REQ; k++) begin
         if (grant_q[k]) begin
            own_data  = i_req_data[8*k +: 8];
            own_valid = i_req_valid[k];
            own_last  = i_req_last[k];
         end
      end
   end

   always_comb begin
      tx_fire     = 1'b0;
      o_req_ready = '0;
      o_tx_data   = 8'h00;
      if (state_q == S_SEND) begin
`ifdef UART_ARB_HEADER_EN
         if (hdr_q) begin
            tx_fire   = !i_tx_busy && (grant_q != '0);
            o_tx_data = HDR_BASE | 8'(idx_q);
         end else begin
            tx_fire     = own_valid && !i_tx_busy;
            o_req_ready = tx_fire ? grant_q : '0;
            o_tx_data   = own_data;
         end
`else
         tx_fire     = own_valid && !i_tx_busy;
         o_req_ready = tx_fire ? grant_q : '0;
         o_tx_data   = own_data;
`endif
      end
   end

   assign o_tx_valid = tx_fire;
   assign next_ptr   = (idx_q == IW'(NUM_REQ - 1)) ? '0 : idx_q + 1'b1;

   always_ff @(posedge i_clk) begin
      if (i_reset) begin
         state_q  <= S_ARB;
         ptr_q    <= '0;
         idx_q    <= '0;
         burst_q  <= '0;
         grant_q  <= '0;
         last_q   <= 1'b0;
         active_q <= 1'b0;
`ifdef UART_ARB_HEADER_EN
         hdr_q    <= 1'b0;
`endif
      end else begin
         case (state_q)
            S_ARB: begin
               if (pick_any) begin
                  grant_q  <= pick_gnt;
                  idx_q    <= pick_idx;
                  burst_q  <= '0;
                  last_q   <= 1'b0;
                  active_q <= 1'b1;
                  state_q  <= S_SEND;
`ifdef UART_ARB_HEADER_EN
                  hdr_q    <= 1'b1;
`endif
               end
            end
            S_SEND: begin
               if (tx_fire) begin
                  state_q <= S_WAIT_BUSY;
`ifdef UART_ARB_HEADER_EN
                  if (hdr_q) begin
                     hdr_q  <= 1'b0;
                     last_q <= 1'b0;
                  end else begin
                     last_q  <= own_last;
                     burst_q <= burst_q + 1'b1;
                  end
`else
                  last_q  <= own_last;
                  burst_q <= burst_q + 1'b1;
`endif
               end
            end
            S_WAIT_BUSY: begin
               if (i_tx_busy) begin
                  state_q <= S_WAIT_DONE;
               end
            end
            S_WAIT_DONE: begin
               if (!i_tx_busy) begin
                  // A burst-limited release leaves the rest of the packet to a fresh arbitration.
                  if (last_q || (burst_q == BW'(MAX_BURST))) begin
                     ptr_q    <= next_ptr;
                     grant_q  <= '0;
                     active_q <= 1'b0;
                     state_q  <= S_ARB;
                  end else begin
                     state_q <= S_SEND;
                  end
               end
            end
            default: begin
               state_q  <= S_ARB;
               grant_q  <= '0;
               burst_q  <= '0;
               last_q   <= 1'b0;
               active_q <= 1'b0;
`ifdef UART_ARB_HEADER_EN
               hdr_q    <= 1'b0;
`endif
            end
         endcase
      end
   end

   assign o_grant  = grant_q;
   assign o_active = active_q;

`ifndef SYNTHESIS
   always @(posedge i_clk) begin
      if (!i_reset) begin
         assert ($onehot0(grant_q))
            else $error("uart_tx_arbiter: grant vector has more than one bit set");
         assert (!(tx_fire && i_tx_busy))
            else $error("uart_tx_arbiter: tx strobe raised while transmitter busy");
      end
   end
`endif

endmodule

// File: tb/tb_uart_tx_arbiter.sv
// Self-checking bench for uart_tx_arbiter: vector table, directed corner sequences, randomized traffic vs a packet-level model.
module tb_uart_tx_arbiter;

   localparam int NR = 4;
   localparam int MB = 16;

   logic            clk = 1'b0;
   logic            rst = 1'b1;
   logic [NR-1:0]   vld;
   logic [NR-1:0]   lst;
   logic [NR*8-1:0] dat;
   logic            busy;
   logic [NR-1:0]   rdy;
   logic [NR-1:0]   gnt;
   logic            txv;
   logic [7:0]      txd;
   logic            act;

   always #5 clk = ~clk;

   uart_tx_arbiter #(.NUM_REQ(NR), .MAX_BURST(MB)) dut (
      .i_clk       (clk),
      .i_reset     (rst),
      .i_req_valid (vld),
      .i_req_data  (dat),
      .i_req_last  (lst),
      .o_req_ready (rdy),
      .o_tx_valid  (txv),
      .o_tx_data   (txd),
      .i_tx_busy   (busy),
      .o_grant     (gnt),
      .o_active    (act)
   );

   typedef struct {
      int         owner;
      logic [7:0] b;
   } txrec_t;

   typedef struct {
      logic [NR-1:0] v;
      logic          bz;
      logic [NR-1:0] g;
      logic          tv;
      logic [7:0]    d;
   } vec_t;

   int            checks = 0;
   int            errors = 0;
   logic [8:0]    rq [NR][$];
   logic [NR-1:0] en;
   int            busy_cnt, busy_min, busy_max;
   logic          strobe_prev;
   int            cyc;
   int            m_ptr;
   int            rdy_cnt [NR];
   txrec_t        obs_q[$];
   txrec_t        exp_q[$];
   int            obs_cyc[$];
   logic [NR-1:0] glog[$];
   logic [NR-1:0] last_gnt;

   task automatic chk(input string name, input logic [31:0] a, input logic [31:0] e);
      checks++;
      if (a !== e) begin
         errors++;
         $display("FAIL %s: got %0h expected %0h", name, a, e);
      end
   endtask

   function automatic int oh2idx(input logic [NR-1:0] g);
      int r;
      r = -1;
      for (int k = 0; k < NR; k++) if (g == (NR'(1) << k)) r = k;
      return r;
   endfunction

   // One bench cycle: update the UART busy model, drive requesters, then observe what the next edge will accept.
   task automatic tick();
      txrec_t r;
      @(negedge clk);
      cyc++;
      if (strobe_prev) busy_cnt = (busy_min == busy_max) ? busy_min : int'($urandom_range(busy_max, busy_min));
      else if (busy_cnt > 0) busy_cnt--;
      busy = (busy_cnt > 0);
      for (int k = 0; k < NR; k++) begin
         vld[k] = en[k] && (rq[k].size() > 0);
         dat[8*k +: 8] = vld[k] ? rq[k][0][7:0] : 8'h00;
         lst[k] = vld[k] ? rq[k][0][8] : 1'b0;
      end
      #1;
      strobe_prev = txv;
      if (txv) begin
         r.owner = oh2idx(gnt);
         r.b     = txd;
         obs_q.push_back(r);
         obs_cyc.push_back(cyc);
      end
      for (int k = 0; k < NR; k++) begin
         if (rdy[k] && vld[k]) begin
            void'(rq[k].pop_front());
            rdy_cnt[k]++;
         end
      end
      if (gnt !== last_gnt) begin
         glog.push_back(gnt);
         last_gnt = gnt;
      end
   endtask

   task automatic do_reset();
      @(negedge clk);
      rst = 1'b1;
      @(negedge clk);
      #1;
      chk("reset grant", 32'(gnt), 32'h0);
      chk("reset active", 32'(act), 32'h0);
      chk("reset ready", 32'(rdy), 32'h0);
      chk("reset tx_valid", 32'(txv), 32'h0);
      chk("reset tx_data", 32'(txd), 32'h0);
      rst = 1'b0;
      vld = '0; dat = '0; lst = '0; busy = 1'b0;
      for (int k = 0; k < NR; k++) begin
         rq[k].delete();
         rdy_cnt[k] = 0;
      end
      busy_cnt = 0; strobe_prev = 1'b0; m_ptr = 0; en = '1; last_gnt = '0;
   endtask

   // Packet-level model: round-robin over non-empty queues, each grant sends up to MB bytes or to end of packet.
   task automatic build_model();
      logic [8:0] c [NR][$];
      logic [8:0] b;
      txrec_t     r;
      int         k, n;
      bit         done;
      for (int i = 0; i < NR; i++) c[i] = rq[i];
      while (1) begin
         k = -1;
         for (int i = 0; i < NR; i++) if (k < 0 && c[(m_ptr + i) % NR].size() > 0) k = (m_ptr + i) % NR;
         if (k < 0) break;
`ifdef UART_ARB_HEADER_EN
         r.owner = k;
         r.b     = 8'hA0 | 8'(k);
         exp_q.push_back(r);
`endif
         n = 0;
         done = 0;
         while (!done) begin
            b = c[k].pop_front();
            r.owner = k;
            r.b     = b[7:0];
            exp_q.push_back(r);
            n++;
            done = b[8] || (n == MB) || (c[k].size() == 0);
         end
         m_ptr = (k + 1) % NR;
      end
   endtask

   task automatic begin_traffic();
      exp_q.delete();
      obs_q.delete();
      obs_cyc.delete();
      build_model();
   endtask

   task automatic finish_traffic(input string name, input int budget);
      int t, n;
      bit idle;
      t = 0;
      idle = 0;
      while (!idle && t < budget) begin
         tick();
         t++;
         idle = !act && busy_cnt == 0 && !strobe_prev;
         for (int k = 0; k < NR; k++) if (rq[k].size() > 0) idle = 0;
      end
      chk({name, " finished in budget"}, 32'(idle), 32'h1);
      chk({name, " byte count"}, 32'(obs_q.size()), 32'(exp_q.size()));
      n = (obs_q.size() < exp_q.size()) ? obs_q.size() : exp_q.size();
      for (int i = 0; i < n; i++) begin
         chk($sformatf("%s byte%0d data", name, i), 32'(obs_q[i].b), 32'(exp_q[i].b));
         chk($sformatf("%s byte%0d owner", name, i), 32'(obs_q[i].owner), 32'(exp_q[i].owner));
      end
   endtask

   task automatic run_traffic(input string name, input int budget);
      begin_traffic();
      finish_traffic(name, budget);
   endtask

   initial begin
      #2_000_000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      vec_t vt [7];
      logic [7:0]    exp_d;
      logic [NR-1:0] exp_r;
      int            bad, n0;

      vld = '0; dat = '0; lst = '0; busy = 1'b0; en = '1;
      busy_min = 10; busy_max = 10; cyc = 0; m_ptr = 0;
      busy_cnt = 0; strobe_prev = 1'b0; last_gnt = '0;

      vt[0] = '{v: 4'b0000, bz: 1'b0, g: 4'b0000, tv: 1'b0, d: 8'h00};
      vt[1] = '{v: 4'b0001, bz: 1'b0, g: 4'b0001, tv: 1'b1, d: 8'h05};
      vt[2] = '{v: 4'b0110, bz: 1'b0, g: 4'b0010, tv: 1'b1, d: 8'h15};
      vt[3] = '{v: 4'b1100, bz: 1'b1, g: 4'b0100, tv: 1'b0, d: 8'h25};
      vt[4] = '{v: 4'b1000, bz: 1'b0, g: 4'b1000, tv: 1'b1, d: 8'h35};
      vt[5] = '{v: 4'b1111, bz: 1'b0, g: 4'b0001, tv: 1'b1, d: 8'h05};
      vt[6] = '{v: 4'b0101, bz: 1'b1, g: 4'b0001, tv: 1'b0, d: 8'h05};

      for (int i = 0; i < 7; i++) begin
         do_reset();
         vld  = vt[i].v;
         busy = vt[i].bz;
         lst  = '0;
         for (int k = 0; k < NR; k++) dat[8*k +: 8] = 8'(16 * k + 5);
         @(negedge clk);
         #1;
         exp_d = vt[i].d;
         exp_r = vt[i].tv ? vt[i].g : '0;
`ifdef UART_ARB_HEADER_EN
         if (vt[i].g != '0) exp_d = 8'hA0 | 8'(oh2idx(vt[i].g));
         exp_r = '0;
`endif
         chk($sformatf("vec%0d grant", i), 32'(gnt), 32'(vt[i].g));
         chk($sformatf("vec%0d active", i), 32'(act), 32'(vt[i].g != '0));
         chk($sformatf("vec%0d tx_valid", i), 32'(txv), 32'(vt[i].tv));
         chk($sformatf("vec%0d ready", i), 32'(rdy), 32'(exp_r));
         chk($sformatf("vec%0d tx_data", i), 32'(txd), 32'(exp_d));
      end
      do_reset();

      // Three bytes from requester 0 with a 10-cycle busy pulse per byte.
      rq[0] = '{9'h011, 9'h022, 9'h133};
      run_traffic("t1", 400);
      for (int i = 1; i < obs_cyc.size(); i++)
         chk($sformatf("t1 spacing%0d>=12", i), 32'(obs_cyc[i] - obs_cyc[i-1] >= 12), 32'h1);
      chk("t1 grant released", 32'(gnt), 32'h0);

      // Pointer now 1: requester 2 must win over requester 0.
      glog.delete();
      rq[0] = '{9'h1AA};
      rq[2] = '{9'h1BB};
      run_traffic("t2", 400);
      chk("t2 grant changes", 32'(glog.size() >= 3), 32'h1);
      if (glog.size() >= 3) begin
         chk("t2 grant seq0", 32'(glog[0]), 32'b0100);
         chk("t2 grant seq1", 32'(glog[1]), 32'b0000);
         chk("t2 grant seq2", 32'(glog[2]), 32'b0001);
      end

      // 20-byte packet forced to release after MB bytes; requester 3 served in between.
      for (int i = 0; i < 20; i++) rq[1].push_back({(i == 19), 8'(8'h40 + i)});
      rq[3] = '{9'h0C1, 9'h1C2};
      run_traffic("t3", 1500);

      // Requester 2 drops valid for 50 cycles mid-packet.
      for (int i = 0; i < 6; i++) rq[2].push_back({(i == 5), 8'(8'h70 + i)});
      begin_traffic();
      n0 = 0;
      while (obs_q.size() < 2 && n0 < 200) begin
         tick();
         n0++;
      end
      chk("t4 first bytes sent", 32'(obs_q.size() >= 2), 32'h1);
      en[2] = 1'b0;
      n0 = obs_q.size();
      bad = 0;
      repeat (50) begin
         tick();
         if (gnt !== 4'b0100) bad++;
      end
      chk("t4 strobes during gap", 32'(obs_q.size() - n0), 32'h0);
      chk("t4 grant held cycles wrong", 32'(bad), 32'h0);
      en[2] = 1'b1;
      finish_traffic("t4", 600);

      // Reset while the transmitter is busy with a byte; pointer must restart at 0.
      rq[2] = '{9'h001, 9'h002, 9'h103};
      begin_traffic();
      n0 = 0;
      while (obs_q.size() < 1 && n0 < 200) begin
         tick();
         n0++;
      end
      chk("t5 byte before reset", 32'(obs_q.size()), 32'h1);
      repeat (3) tick();
      chk("t5 mid-byte active", 32'(act && busy), 32'h1);
      do_reset();
      rq[0] = '{9'h15A};
      rq[1] = '{9'h16B};
      run_traffic("t5", 400);
      chk("t5 first owner after reset", 32'(obs_q.size() > 0 ? obs_q[0].owner : -1), 32'h0);

      // Single-byte packet from requester 3: exactly one accept strobe.
      rdy_cnt[3] = 0;
      rq[3] = '{9'h155};
      run_traffic("t6", 200);
      chk("t6 ready pulses", 32'(rdy_cnt[3]), 32'h1);

      // Randomized packets and random busy lengths.
      busy_min = 2;
      busy_max = 12;
      for (int round = 0; round < 4; round++) begin
         for (int k = 0; k < NR; k++) begin
            int npk;
            npk = int'($urandom_range(2, 0));
            for (int p = 0; p < npk; p++) begin
               int len;
               len = int'($urandom_range(22, 1));
               for (int i = 0; i < len; i++) rq[k].push_back({(i == len - 1), 8'($urandom)});
            end
         end
         run_traffic($sformatf("rnd%0d", round), 8000);
      end

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
